// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 two-level page-table walker: one PTE read in flight, single-cycle TLB refill or fault on completion.
// Latency (zero-wait memory): 4MiB done at +2, 4KiB at +4 after walk_req_i; stalls in REQ without gnt, in WAIT/DRAIN without rvalid.
package cva6_ptw_sv32_pkg;
  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef struct packed {
    logic        valid;
    logic        is_4M;
    logic [19:0] vpn;
    logic [8:0]  asid;
    pte_sv32_t   content;
  } tlb_update_sv32_t;
endpackage

module cva6_ptw_sv32_walker
  import cva6_ptw_sv32_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned PLEN       = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  walk_req_i,
  input  logic [31:0]           walk_vaddr_i,
  input  logic [ASID_WIDTH-1:0] walk_asid_i,
  input  logic                  walk_is_itlb_i,
  input  logic                  walk_is_store_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  mxr_i,
  output logic                  mem_req_o,
  output logic [PLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  walk_busy_o,
  output logic                  walk_done_o,
  output logic                  walk_page_fault_o,
  output logic                  walk_acc_fault_o,
  output tlb_update_sv32_t      update_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  level_q, level_d;
  logic [PLEN-1:0]       addr_q, addr_d;
  logic [19:0]           vpn_q, vpn_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic                  itlb_q, itlb_d;
  logic                  store_q, store_d;

  pte_sv32_t pte;
  logic      perm_ok;
  logic      dec_acc, dec_pf, dec_next, dec_ok;
  logic      rsp_live;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      addr_q  <= '0;
      vpn_q   <= '0;
      asid_q  <= '0;
      itlb_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      level_q <= level_d;
      addr_q  <= addr_d;
      vpn_q   <= vpn_d;
      asid_q  <= asid_d;
      itlb_q  <= itlb_d;
      store_q <= store_d;
    end
  end

  // PTE decode; only meaningful while a response is presented in WAIT.
  always_comb begin
    pte     = pte_sv32_t'(mem_rdata_i);
    perm_ok = pte.a;
    if (itlb_q) begin
      perm_ok = perm_ok & pte.x;
    end else if (store_q) begin
      perm_ok = perm_ok & pte.w & pte.d;
    end else begin
      perm_ok = perm_ok & (pte.r | (pte.x & mxr_i));
    end

    dec_acc  = 1'b0;
    dec_pf   = 1'b0;
    dec_next = 1'b0;
    dec_ok   = 1'b0;
    if (mem_err_i) begin
      dec_acc = 1'b1;
    end else if (!pte.v || (!pte.r && pte.w)) begin
      dec_pf = 1'b1;
    end else if (!pte.r && !pte.x) begin
      if (level_q) begin
        dec_next = 1'b1;
      end else begin
        dec_pf = 1'b1;
      end
    end else if ((level_q && (pte.ppn[9:0] != 10'd0)) || !perm_ok) begin
      dec_pf = 1'b1;
    end else begin
      dec_ok = 1'b1;
    end

    rsp_live = (state_q == WAIT) && mem_rvalid_i && !flush_i;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    addr_d  = addr_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    itlb_d  = itlb_q;
    store_d = store_q;
    unique case (state_q)
      IDLE: begin
        if (walk_req_i) begin
          state_d = REQ;
          level_d = 1'b1;
          vpn_d   = walk_vaddr_i[31:12];
          asid_d  = walk_asid_i;
          itlb_d  = walk_is_itlb_i;
          store_d = walk_is_store_i;
          addr_d  = PLEN'({satp_ppn_i, walk_vaddr_i[31:22], 2'b00});
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A flush with no response yet still owes us one rvalid to swallow.
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          if (dec_next) begin
            state_d = REQ;
            level_d = 1'b0;
            addr_d  = PLEN'({pte.ppn, vpn_q[9:0], 2'b00});
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o         = (state_q == REQ);
    mem_addr_o        = (state_q == REQ) ? addr_q : '0;
    walk_busy_o       = (state_q != IDLE);
    walk_done_o       = rsp_live && (dec_acc || dec_pf || dec_ok);
    walk_page_fault_o = rsp_live && dec_pf;
    walk_acc_fault_o  = rsp_live && dec_acc;
    update_o          = '0;
    if (rsp_live && dec_ok) begin
      update_o.valid   = 1'b1;
      update_o.is_4M   = level_q;
      update_o.vpn     = vpn_q;
      update_o.asid    = 9'(asid_q);
      update_o.content = pte;
    end
  end

endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
// Directed bench for the Sv32 walker: zero-wait memory responder, hand-computed PTE addresses and outcomes.
module tb_cva6_ptw_sv32_walker;
  import cva6_ptw_sv32_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             walk_req_i;
  logic [31:0]      walk_vaddr_i;
  logic [0:0]       walk_asid_i;
  logic             walk_is_itlb_i;
  logic             walk_is_store_i;
  logic [21:0]      satp_ppn_i;
  logic             mxr_i;
  logic             mem_req_o;
  logic [33:0]      mem_addr_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [31:0]      mem_rdata_i;
  logic             mem_err_i;
  logic             walk_busy_o;
  logic             walk_done_o;
  logic             walk_page_fault_o;
  logic             walk_acc_fault_o;
  tlb_update_sv32_t update_o;

  int n_tests = 0;
  int n_fail  = 0;

  cva6_ptw_sv32_walker #(.ASID_WIDTH(1), .PLEN(34)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .walk_req_i        (walk_req_i),
    .walk_vaddr_i      (walk_vaddr_i),
    .walk_asid_i       (walk_asid_i),
    .walk_is_itlb_i    (walk_is_itlb_i),
    .walk_is_store_i   (walk_is_store_i),
    .satp_ppn_i        (satp_ppn_i),
    .mxr_i             (mxr_i),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .mem_err_i         (mem_err_i),
    .walk_busy_o       (walk_busy_o),
    .walk_done_o       (walk_done_o),
    .walk_page_fault_o (walk_page_fault_o),
    .walk_acc_fault_o  (walk_acc_fault_o),
    .update_o          (update_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Zero-wait memory: gnt in the request cycle, rvalid in the following cycle.
  task automatic run_walk(input string tag, input logic [31:0] va, input logic st, input logic it,
                          input logic mx, input logic [31:0] pte_a, input logic [31:0] pte_b,
                          input logic err_b, input logic [33:0] addr_a, input logic [33:0] addr_b,
                          input int exp_cyc, input logic exp_pf, input logic exp_af,
                          input logic exp_upd, input logic exp_4m);
    int          nreq;
    logic        rv, er, done_seen;
    logic [31:0] rd;
    nreq = 0; rv = 1'b0; er = 1'b0; rd = '0; done_seen = 1'b0;
    @(negedge clk_i);
    walk_req_i = 1'b1; walk_vaddr_i = va; walk_is_store_i = st; walk_is_itlb_i = it;
    mxr_i = mx; walk_asid_i = 1'b1;
    #1;
    check_eq({tag, ".idle_busy"}, walk_busy_o, 0);
    for (int c = 1; c <= 12 && !done_seen; c++) begin
      @(negedge clk_i);
      walk_req_i = 1'b0; walk_asid_i = 1'b0;
      mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er; mem_gnt_i = 1'b0;
      rv = 1'b0; er = 1'b0;
      #1;
      if (mem_req_o) begin
        check_eq({tag, ".addr"}, mem_addr_o, (nreq == 0) ? addr_a : addr_b);
        mem_gnt_i = 1'b1;
        rv = 1'b1;
        rd = (nreq == 0) ? pte_a : pte_b;
        er = (nreq == 0) ? 1'b0 : err_b;
        nreq++;
      end
      if (walk_done_o) begin
        done_seen = 1'b1;
        check_eq({tag, ".cycle"}, c, exp_cyc);
        check_eq({tag, ".pf"}, walk_page_fault_o, exp_pf);
        check_eq({tag, ".af"}, walk_acc_fault_o, exp_af);
        check_eq({tag, ".upd"}, update_o.valid, exp_upd);
        if (exp_upd) begin
          check_eq({tag, ".is4M"}, update_o.is_4M, exp_4m);
          check_eq({tag, ".vpn"}, update_o.vpn, va[31:12]);
          check_eq({tag, ".asid"}, update_o.asid, 9'h001);
          check_eq({tag, ".content"}, update_o.content, exp_4m ? pte_a : pte_b);
        end
      end
    end
    if (!done_seen) check_eq({tag, ".timeout"}, 0, 1);
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    walk_is_store_i = 1'b0; walk_is_itlb_i = 1'b0; mxr_i = 1'b0;
    #1;
    check_eq({tag, ".back_idle"}, walk_busy_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; walk_req_i = 1'b0; walk_vaddr_i = '0; walk_asid_i = '0;
    walk_is_itlb_i = 1'b0; walk_is_store_i = 1'b0; satp_ppn_i = 22'h00080; mxr_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    #12;
    check_eq("rst.busy", walk_busy_o, 0);
    check_eq("rst.req", mem_req_o, 0);
    check_eq("rst.addr", mem_addr_o, 0);
    check_eq("rst.done", walk_done_o, 0);
    check_eq("rst.update", update_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // satp 0x80 -> root table at 0x80000; vpn1 0x001 -> +0x4, vpn1 0x200 -> +0x800
    run_walk("t1_4k",      32'h0040_1000, 0, 0, 0, 32'h0002_0001, 32'h0003_00CF, 0, 34'h8_0004, 34'h8_0004, 4, 0, 0, 1, 0);
    run_walk("t2_4m",      32'h8000_0000, 0, 0, 0, 32'h2000_00CF, 32'h0,         0, 34'h8_0800, 34'h0,      2, 0, 0, 1, 1);
    run_walk("t3_st_d0",   32'h0040_1000, 1, 0, 0, 32'h0002_0001, 32'h0003_004B, 0, 34'h8_0004, 34'h8_0004, 4, 1, 0, 0, 0);
    run_walk("t4_l0_ptr",  32'h0040_1000, 0, 0, 0, 32'h0000_0401, 32'h0000_0001, 0, 34'h8_0004, 34'h0_1004, 4, 1, 0, 0, 0);
    run_walk("t4_misal",   32'h8000_0000, 0, 0, 0, 32'h0000_04CF, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);
    run_walk("t5_err",     32'h0040_1000, 0, 0, 0, 32'h0002_0001, 32'h0003_00CF, 1, 34'h8_0004, 34'h8_0004, 4, 0, 1, 0, 0);
    run_walk("p_itlb_nx",  32'h8000_0000, 0, 1, 0, 32'h2000_00C7, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);
    run_walk("p_itlb_x",   32'h8000_0000, 1, 1, 0, 32'h2000_00C9, 32'h0,         0, 34'h8_0800, 34'h0,      2, 0, 0, 1, 1);
    run_walk("p_mxr1",     32'h8000_0000, 0, 0, 1, 32'h2000_00C9, 32'h0,         0, 34'h8_0800, 34'h0,      2, 0, 0, 1, 1);
    run_walk("p_mxr0",     32'h8000_0000, 0, 0, 0, 32'h2000_00C9, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);
    run_walk("p_a0",       32'h8000_0000, 0, 0, 0, 32'h2000_008F, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);
    run_walk("p_st_ok",    32'h8000_0000, 1, 0, 0, 32'h2000_00C7, 32'h0,         0, 34'h8_0800, 34'h0,      2, 0, 0, 1, 1);
    run_walk("p_st_d0",    32'h8000_0000, 1, 0, 0, 32'h2000_0047, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);
    run_walk("p_w_nr",     32'h8000_0000, 0, 0, 0, 32'h2000_0005, 32'h0,         0, 34'h8_0800, 34'h0,      2, 1, 0, 0, 0);

    // Flush in WAIT, response three cycles later must be swallowed silently.
    @(negedge clk_i); walk_req_i = 1'b1; walk_vaddr_i = 32'h8000_0000;
    @(negedge clk_i); walk_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check_eq("t6.req", mem_req_o, 1);
    @(negedge clk_i); mem_gnt_i = 1'b0; flush_i = 1'b1; #1;
    check_eq("t6.flush_done", walk_done_o, 0);
    @(negedge clk_i); flush_i = 1'b0; #1;
    check_eq("t6.drain_busy", walk_busy_o, 1);
    check_eq("t6.drain_req", mem_req_o, 0);
    @(negedge clk_i);
    @(negedge clk_i); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF; #1;
    check_eq("t6.drop_upd", update_o.valid, 0);
    check_eq("t6.drop_done", walk_done_o, 0);
    check_eq("t6.drop_busy", walk_busy_o, 1);
    @(negedge clk_i); mem_rvalid_i = 1'b0; walk_req_i = 1'b1; #1;
    check_eq("t6.idle", walk_busy_o, 0);
    @(negedge clk_i); walk_req_i = 1'b0; #1;
    check_eq("t6.new_req", mem_req_o, 1);
    check_eq("t6.new_addr", mem_addr_o, 34'h8_0800);
    mem_gnt_i = 1'b1;
    @(negedge clk_i); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; #1;
    check_eq("t6.new_done", walk_done_o, 1);
    check_eq("t6.new_upd", update_o.valid, 1);
    @(negedge clk_i); mem_rvalid_i = 1'b0;

    // Flush in REQ without gnt returns straight to IDLE.
    @(negedge clk_i); walk_req_i = 1'b1;
    @(negedge clk_i); walk_req_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0; #1;
    check_eq("fr.idle", walk_busy_o, 0);

    // Flush alongside a valid leaf response: no refill, no done.
    @(negedge clk_i); walk_req_i = 1'b1;
    @(negedge clk_i); walk_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; flush_i = 1'b1; #1;
    check_eq("fw.done", walk_done_o, 0);
    check_eq("fw.upd", update_o.valid, 0);
    @(negedge clk_i); mem_rvalid_i = 1'b0; flush_i = 1'b0; #1;
    check_eq("fw.idle", walk_busy_o, 0);

    // Reset mid-walk, then a stale response arrives in IDLE.
    @(negedge clk_i); walk_req_i = 1'b1;
    @(negedge clk_i); walk_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i); mem_gnt_i = 1'b0; rst_ni = 1'b0; #1;
    check_eq("rw.busy", walk_busy_o, 0);
    @(negedge clk_i); rst_ni = 1'b1; mem_rvalid_i = 1'b1; #1;
    check_eq("rw.stale_done", walk_done_o, 0);
    check_eq("rw.stale_upd", update_o.valid, 0);
    @(negedge clk_i); mem_rvalid_i = 1'b0; #1;
    check_eq("rw.idle", walk_busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
